// File: rtl/crc_rx_frame_buffer.sv
// Receive frame buffer: Ethernet CRC-32 check, 4-byte FCS strip, good frames committed to a ring.
// Define CRC_CHECK_EN to discard frames whose FCS is wrong; otherwise every complete frame is kept.
module crc_rx_frame_buffer #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] udp_rx,
  input  logic       udp_rx_valid,
  input  logic       udp_rx_first,
  input  logic       udp_rx_last,
  input  logic       rd_en,
  output logic [7:0] rddata,
  output logic       rd_valid,
  output logic       rd_first,
  output logic       rd_last,
  output logic       empty,
  output logic       drop
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DLY_N  = 4;

  typedef struct packed {
    logic              first;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DROP} state_t;

  state_t                        state, state_nxt;
  entry_t                        mem [DEPTH];
  entry_t                        rd_entry;
  logic [ADDR_W-1:0]             wr_ptr, commit_ptr, rd_ptr, wr_ptr_inc;
  logic [DLY_N-1:0][DATA_W-1:0]  dly;
  logic [1:0]                    fill_cnt;
  logic                          first_pend;
  logic                          sof_c, full_c, crc_good_c;
  logic                          push_c, commit_c, rewind_c, drop_c;

  assign sof_c      = udp_rx_valid && udp_rx_first;
  assign wr_ptr_inc = wr_ptr + ADDR_W'(1);
  assign full_c     = (wr_ptr_inc == rd_ptr);
  assign empty      = (rd_ptr == commit_ptr);
  assign rd_entry   = mem[rd_ptr];

`ifdef CRC_CHECK_EN
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0] crc, crc_nxt;

  // CRC covers the whole frame including FCS, so a good frame lands on the fixed residue
  assign crc_nxt    = crc_byte(sof_c ? CRC_INIT : crc, udp_rx);
  assign crc_good_c = (crc_nxt == CRC_RESIDUE);

  always_ff @(posedge clk) begin
    if (rst)               crc <= CRC_INIT;
    else if (udp_rx_valid) crc <= crc_nxt;
  end
`else
  assign crc_good_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sof_c) begin
      state_nxt = udp_rx_last ? S_IDLE : S_FILL;
    end else if (udp_rx_valid) begin
      case (state)
        S_FILL:   if (udp_rx_last) state_nxt = S_IDLE;
                  else if (fill_cnt == 2'd3) state_nxt = S_STREAM;
        S_STREAM: if (udp_rx_last) state_nxt = S_IDLE;
                  else if (full_c) state_nxt = S_DROP;
        S_DROP:   if (udp_rx_last) state_nxt = S_IDLE;
        default:  ;
      endcase
    end
  end

  // A first byte mid-frame abandons the frame in flight; first+last together is a 1-byte short frame
  always_comb begin
    push_c   = 1'b0;
    commit_c = 1'b0;
    rewind_c = 1'b0;
    drop_c   = 1'b0;
    if (sof_c) begin
      rewind_c = (state != S_IDLE);
      drop_c   = (state != S_IDLE) || udp_rx_last;
    end else if (udp_rx_valid) begin
      case (state)
        S_FILL:   drop_c = udp_rx_last;
        S_STREAM: begin
          push_c   = !full_c;
          commit_c = udp_rx_last && !full_c && crc_good_c;
          rewind_c = full_c || (udp_rx_last && !crc_good_c);
          drop_c   = udp_rx_last && !commit_c;
        end
        S_DROP:   drop_c = udp_rx_last;
        default:  ;
      endcase
    end
  end

  // Write side: delay line, speculative/committed pointers; rewind wins over a same-cycle push
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      fill_cnt   <= '0;
      first_pend <= 1'b0;
      dly        <= '0;
      drop       <= 1'b0;
    end else begin
      drop <= drop_c;
      if (udp_rx_valid) dly <= {dly[DLY_N-2:0], udp_rx};
      if (sof_c) begin
        fill_cnt   <= 2'd1;
        first_pend <= 1'b1;
      end else if (udp_rx_valid && (state == S_FILL)) begin
        fill_cnt <= fill_cnt + 2'd1;
      end
      if (push_c) begin
        wr_ptr     <= wr_ptr_inc;
        first_pend <= 1'b0;
      end
      if (commit_c) commit_ptr <= wr_ptr_inc;
      if (rewind_c) wr_ptr     <= commit_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= '{first: first_pend, last: udp_rx_last, data: dly[DLY_N-1]};
  end

  // Read side: outputs hold their last value when nothing is popped
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      rddata   <= '0;
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_en && !empty) begin
        rddata   <= rd_entry.data;
        rd_first <= rd_entry.first;
        rd_last  <= rd_entry.last;
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_crc_rx_frame_buffer.sv
// Scoreboard bench for crc_rx_frame_buffer (ADDR_W=4 so wrap and overflow are reachable);
// expectations follow CRC_CHECK_EN when it is defined for the build.
module tb_crc_rx_frame_buffer;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] udp_rx;
  logic       udp_rx_valid, udp_rx_first, udp_rx_last;
  logic       rd_en;
  logic [7:0] rddata;
  logic       rd_valid, rd_first, rd_last, empty, drop;

  int         total = 0;
  int         bad = 0;
  int         drop_cnt = 0;
  logic [9:0] exp_q[$];

  crc_rx_frame_buffer #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .udp_rx(udp_rx), .udp_rx_valid(udp_rx_valid),
    .udp_rx_first(udp_rx_first), .udp_rx_last(udp_rx_last), .rd_en(rd_en),
    .rddata(rddata), .rd_valid(rd_valid), .rd_first(rd_first), .rd_last(rd_last),
    .empty(empty), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference CRC-32 (xor-in form) used to build the FCS
  function automatic logic [31:0] crc32(input bq_t p);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (p[i]) begin
      c ^= {24'h0, p[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t make_frame(input bq_t p, input bit corrupt);
    bq_t         f = p;
    logic [31:0] fcs = ~crc32(p);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    if (corrupt) f[p.size()] = f[p.size()] ^ 8'h01;
    return f;
  endfunction

  task automatic expect_payload(input bq_t p);
    foreach (p[i]) exp_q.push_back({(i == 0), (i == p.size() - 1), p[i]});
  endtask

  task automatic send_raw(input bq_t b, input bit with_last, input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        udp_rx_valid = 1'b0;
        udp_rx       = 8'($urandom_range(0, 255));
        udp_rx_first = 1'b1;
        udp_rx_last  = 1'b1;
      end
      @(negedge clk);
      udp_rx       = b[i];
      udp_rx_valid = 1'b1;
      udp_rx_first = (i == 0);
      udp_rx_last  = with_last && (i == b.size() - 1);
    end
    @(negedge clk);
    udp_rx_valid = 1'b0;
    udp_rx_first = 1'b0;
    udp_rx_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rd_en = 1'b1;
    while (!(empty && exp_q.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    check({tag, "_left"}, exp_q.size(), 32'd0);
  endtask

  // Output monitor: every delivered byte must match the head of the scoreboard
  always @(negedge clk) begin
    if (drop === 1'b1) drop_cnt++;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rd_unexpected", exp_q.size(), 32'd1);
      else check("rd_byte", {22'b0, rd_first, rd_last, rddata}, {22'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t pl, p2;
    int  d0;
    rst = 1'b1; rd_en = 1'b0;
    udp_rx = '0; udp_rx_valid = 1'b0; udp_rx_first = 1'b0; udp_rx_last = 1'b0;
    idle(3);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rddata", 32'(rddata), 32'd0);
    check("rst_rd_first", 32'(rd_first), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    rst = 1'b0;
    idle(2);

    // Good frame
    pl = '{8'hfe, 8'h24, 8'h91, 8'h12, 8'ha8, 8'hd9, 8'h02, 8'h99};
    expect_payload(pl);
    send_raw(make_frame(pl, 1'b0), 1'b1, 1'b0);
    check("good_empty", 32'(empty), 32'd0);
    drain("good");

    // Bad FCS
    d0 = drop_cnt;
`ifndef CRC_CHECK_EN
    expect_payload(pl);
`endif
    send_raw(make_frame(pl, 1'b1), 1'b1, 1'b0);
    idle(3);
`ifdef CRC_CHECK_EN
    check("bad_drop", drop_cnt - d0, 32'd1);
    check("bad_empty", 32'(empty), 32'd1);
`else
    check("bad_drop", drop_cnt - d0, 32'd0);
    drain("bad");
`endif

    // Short 4-byte frame
    d0 = drop_cnt;
    send_raw('{8'h01, 8'h02, 8'h03, 8'h04}, 1'b1, 1'b0);
    idle(3);
    check("short_drop", drop_cnt - d0, 32'd1);
    check("short_empty", 32'(empty), 32'd1);

    // Abort by a new first, then a 6-byte good frame
    d0 = drop_cnt;
    send_raw('{8'ha1, 8'ha2, 8'ha3}, 1'b0, 1'b0);
    p2 = '{8'h5a, 8'hc3};
    expect_payload(p2);
    send_raw(make_frame(p2, 1'b0), 1'b1, 1'b0);
    idle(2);
    check("abort_drop", drop_cnt - d0, 32'd1);
    drain("abort");

    // Wrap: 20 frames through a 16-entry ring, with input gaps
    d0 = drop_cnt;
    for (int f = 0; f < 20; f++) begin
      pl = {};
      for (int i = 0; i < 9; i++) pl.push_back(8'($urandom_range(0, 255)));
      expect_payload(pl);
      send_raw(make_frame(pl, 1'b0), 1'b1, 1'b1);
      drain("wrap");
    end
    check("wrap_drop", drop_cnt - d0, 32'd0);

    // Overflow: 9 bytes held unread, then a 20-byte frame that cannot fit
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    expect_payload(pl);
    send_raw(make_frame(pl, 1'b0), 1'b1, 1'b0);
    d0 = drop_cnt;
    p2 = {};
    for (int i = 0; i < 16; i++) p2.push_back(8'(8'hb0 + i));
    send_raw(make_frame(p2, 1'b0), 1'b1, 1'b0);
    idle(3);
    check("ovf_drop", drop_cnt - d0, 32'd1);
    check("ovf_empty", 32'(empty), 32'd0);
    drain("ovf");

    // Reset mid-frame; outputs still hold 0x99/last from the previous read
    send_raw('{8'hc1, 8'hc2, 8'hc3}, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_rd_valid", 32'(rd_valid), 32'd0);
    check("mrst_rddata", 32'(rddata), 32'd0);
    check("mrst_rd_first", 32'(rd_first), 32'd0);
    check("mrst_rd_last", 32'(rd_last), 32'd0);
    check("mrst_drop", 32'(drop), 32'd0);
    rst = 1'b0;
    idle(1);
    pl = '{8'h0d, 8'hf0, 8'h0d, 8'h42, 8'h17};
    expect_payload(pl);
    send_raw(make_frame(pl, 1'b0), 1'b1, 1'b0);
    check("mrst_good_empty", 32'(empty), 32'd0);
    drain("mrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_rx_frame_buffer.md
# crc_rx_frame_buffer

Receive-side CRC-checking frame buffer for the UDP datapath. It accepts a byte stream framed by first/last strobes, computes Ethernet CRC-32 on the fly and strips the 4-byte trailing FCS. Good frames are committed into a ring buffer; bad or truncated frames are discarded. A downstream consumer pops payload bytes with first/last markers.

## Interface
- `ADDR_W`, default 8: ring depth is 2^ADDR_W entries. Each entry holds 8 data bits plus first and last flags.
- `clk` input 1: single clock for write and read sides.
- `rst` input 1: synchronous, active-high reset.
- `udp_rx` input 8: incoming byte.
- `udp_rx_valid` input 1: `udp_rx` is valid this cycle.
- `udp_rx_first` input 1: first byte of a frame; qualified by valid.
- `udp_rx_last` input 1: last byte of a frame, i.e. FCS byte 3; qualified by valid.
- `rd_en` input 1: pop request.
- `rddata` output 8: popped byte, registered.
- `rd_valid` output 1: `rddata`/`rd_first`/`rd_last` were updated this cycle.
- `rd_first` output 1: popped byte is the first payload byte of its frame.
- `rd_last` output 1: popped byte is the last payload byte of its frame.
- `empty` output 1: no committed, unread byte exists.
- `drop` output 1: one-cycle pulse when a frame is discarded.

## Operation
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte-serial LSB-first.
  - The CRC runs over every byte of the frame, FCS included.
  - A frame is good when the register equals the residue 0xDEBB20E3 after the last byte.
  - The FCS is ~CRC(payload), transmitted least-significant byte first.
- Delay line: a 4-byte delay line holds the most recent bytes.
  - Once it is full, each new valid byte pushes the oldest held byte into the ring at `wr_ptr`, then increments `wr_ptr`.
  - The first pushed byte of a frame is stored with first=1.
  - The byte pushed on the cycle `udp_rx_last` arrives is stored with last=1.
  - The 4 bytes remaining in the delay line are the FCS and are never stored.
- Pointers: `wr_ptr` is speculative, `commit_ptr` is committed, `rd_ptr` is the read pointer. All are ADDR_W bits wide and wrap modulo 2^ADDR_W.
- States:
  - IDLE: waits for valid && first. On that byte, CRC is initialised with it and the state goes to FILL.
  - FILL: collects bytes 2–4. After the 4th byte the state goes to STREAM.
  - STREAM: pushes one byte per valid byte.
  - DROP: ignores bytes until last, then goes to IDLE.
- End of frame (valid && last):
  - In STREAM, if the CRC is good (or checking is disabled), `commit_ptr` is set to `wr_ptr`+1, which includes the byte pushed this cycle.
  - Otherwise `wr_ptr` is set back to `commit_ptr` and `drop` pulses.
  - In both cases the next state is IDLE.
- Short frame: last arriving in IDLE (first && last on the same byte) or in FILL means fewer than 5 bytes. The frame is discarded and `drop` pulses.
- Overflow: if a push would make `wr_ptr`+1 == `rd_ptr`, the byte is not written. `wr_ptr` is set back to `commit_ptr`, the state goes to DROP, and `drop` pulses at the frame's last byte.
- Abort: valid && first while in FILL, STREAM or DROP abandons the current frame and sets `wr_ptr` back to `commit_ptr`. `drop` pulses, and the new byte starts a new frame in FILL.
- Gaps: cycles with valid=0 inside a frame are ignored; the state and the CRC hold.
- `empty` is `rd_ptr` == `commit_ptr`.
- Read side:
  - rd_en && !empty: on the next edge, the ring entry is loaded into `rddata`/`rd_first`/`rd_last`, `rd_valid` is set to 1 and `rd_ptr` increments.
  - rd_en while empty: `rd_valid` is 0 and the outputs hold their previous values.

## Timing
- Reset values: all pointers 0, state IDLE, `empty`=1, `rddata`=0, `rd_valid`=0, `rd_first`=0, `rd_last`=0, `drop`=0.
- Commit latency: `empty` falls on the edge that accepts the last byte. It is visible the cycle after `udp_rx_last`.
- Read latency: 1 cycle from `rd_en` to data. With `rd_en` held high, one byte is delivered per cycle.
- A read and a write in the same cycle are legal. A byte committed this cycle is not readable until the next cycle.
- `drop` asserts on the cycle after the discarding input byte.
- Throughput is 1 byte/cycle on input and 1 byte/cycle on output.

## Configuration
- `CRC_CHECK_EN` defined: bad-CRC frames are discarded and `drop` pulses.
- `CRC_CHECK_EN` undefined:
  - The CRC logic is removed, and every complete frame of at least 5 bytes is committed.
  - The FCS is still stripped.
  - Short frames, overflow and abort still discard.

## Test plan
- Good frame: frame fe 24 91 12 a8 d9 02 99 plus its correct FCS, then `rd_en`=1. Required: `empty` is 0 one cycle after last; reads return fe (`rd_first`=1), 24, 91, 12, a8, d9, 02, 99 (`rd_last`=1); then `empty`=1 and `rd_valid`=0.
- Bad FCS: the same frame with FCS byte 0 XOR 0x01. Required with `CRC_CHECK_EN`: `drop` pulses and `empty` stays 1. Required without it: all 8 payload bytes are delivered.
- Short frame and abort:
  - A 4-byte frame: required `drop` pulse, `empty`=1.
  - A new first arriving mid-frame, followed by a good 6-byte frame: required only the 2 payload bytes of the second frame are delivered.
- Wrap: `ADDR_W`=4, twenty good 9-byte frames, each drained after arrival. Required: every payload is correct with correct first/last flags across the pointer wrap.
- Overflow: `ADDR_W`=4, one good 9-byte frame left unread, then a 20-byte frame. Required: the second frame is dropped with a `drop` pulse, and the first frame reads back intact.
- Reset mid-frame: `rst` asserted after 3 bytes of a frame. Required: all outputs return to their reset values, and a following good frame is delivered normally.
